iob_cache_axi_mem_responder: RTL and testbench

//  AXI4 subordinate (memory-side responder) that terminates the cache back-end AXI4 master.

---
 rtl/iob_cache_axi_mem_responder.sv | 135 +++++++++++++
 tb/tb_iob_cache_axi_mem_responder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/iob_cache_axi_mem_responder.sv
// iob_cache_axi_mem_responder: AXI4 INCR-burst subordinate backed by a word-addressed RAM
module iob_cache_axi_mem_responder #(
    parameter int AXI_ID_W   = 1,
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int MEM_ADDR_W = 10
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [AXI_ID_W-1:0]     axi_awid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
    input  logic                    axi_awvalid_i,
    output logic                    axi_awready_o,
    input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
    input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
    input  logic                    axi_wlast_i,
    input  logic                    axi_wvalid_i,
    output logic                    axi_wready_o,
    output logic [AXI_ID_W-1:0]     axi_bid_o,
    output logic [1:0]              axi_bresp_o,
    output logic                    axi_bvalid_o,
    input  logic                    axi_bready_i,
    input  logic [AXI_ID_W-1:0]     axi_arid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
    input  logic                    axi_arvalid_i,
    output logic                    axi_arready_o,
    output logic [AXI_ID_W-1:0]     axi_rid_o,
    output logic [AXI_DATA_W-1:0]   axi_rdata_o,
    output logic [1:0]              axi_rresp_o,
    output logic                    axi_rlast_o,
    output logic                    axi_rvalid_o,
    input  logic                    axi_rready_i
);
    localparam int NB_W = $clog2(AXI_DATA_W/8);
    localparam int NS   = AXI_DATA_W/8;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic                  run;
    logic [AXI_DATA_W-1:0] mem [2**MEM_ADDR_W];
    logic [AXI_ID_W-1:0]   w_id, r_id;
    logic [MEM_ADDR_W-1:0] w_idx, r_idx, r_idx_nxt, ar_idx;
    logic [AXI_LEN_W-1:0]  w_len, w_cnt, r_len, r_cnt;
    logic                  w_err;
    logic [AXI_DATA_W-1:0] r_data;
    logic                  aw_hs, w_hs, w_end, b_hs, ar_hs, r_hs;
    // run holds the IDLE readies low until the first cycle after reset is released
    assign axi_awready_o = run && w_state == W_IDLE;
    assign axi_wready_o  = w_state == W_DATA;
    assign axi_bvalid_o  = w_state == W_RESP;
    assign axi_bid_o     = w_id;
    assign axi_bresp_o   = {w_err, 1'b0};
    assign axi_arready_o = run && r_state == R_IDLE;
    assign axi_rvalid_o  = r_state == R_DATA;
    assign axi_rlast_o   = axi_rvalid_o && r_cnt == r_len;
    assign axi_rid_o     = r_id;
    assign axi_rdata_o   = r_data;
    assign axi_rresp_o   = 2'b00;
    assign aw_hs     = axi_awvalid_i && axi_awready_o;
    assign w_hs      = axi_wvalid_i && axi_wready_o;
    assign w_end     = w_hs && (axi_wlast_i || w_cnt == w_len);
    assign b_hs      = axi_bvalid_o && axi_bready_i;
    assign ar_hs     = axi_arvalid_i && axi_arready_o;
    assign r_hs      = axi_rvalid_o && axi_rready_i;
    assign ar_idx    = axi_araddr_i[NB_W +: MEM_ADDR_W];
    assign r_idx_nxt = r_idx + 1'b1;
    always_comb begin
        w_next = w_state;
        if (aw_hs) w_next = W_DATA;
        if (w_end) w_next = W_RESP;
        if (b_hs) w_next = W_IDLE;
        r_next = r_state;
        if (ar_hs) r_next = R_DATA;
        if (r_hs && axi_rlast_o) r_next = R_IDLE;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            run     <= 1'b0;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            run     <= 1'b1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_id   <= '0;
            w_idx  <= '0;
            w_len  <= '0;
            w_cnt  <= '0;
            w_err  <= 1'b0;
            r_id   <= '0;
            r_idx  <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
            r_data <= '0;
        end else begin
            if (aw_hs) begin
                w_id  <= axi_awid_i;
                w_idx <= axi_awaddr_i[NB_W +: MEM_ADDR_W];
                w_len <= axi_awlen_i;
                w_cnt <= '0;
                w_err <= 1'b0;
            end
            if (w_hs) begin
                w_idx <= w_idx + 1'b1;
                w_cnt <= w_cnt + 1'b1;
                if (axi_wlast_i && w_cnt != w_len) w_err <= 1'b1;
            end
            if (ar_hs) begin
                r_id   <= axi_arid_i;
                r_idx  <= ar_idx;
                r_len  <= axi_arlen_i;
                r_cnt  <= '0;
                r_data <= mem[ar_idx];
            end
            // prefetch the next word on each accepted beat so bursts run without bubbles
            if (r_hs && !axi_rlast_o) begin
                r_idx  <= r_idx_nxt;
                r_cnt  <= r_cnt + 1'b1;
                r_data <= mem[r_idx_nxt];
            end
        end
    end
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NS; b++)
            if (!rst_i && w_hs && axi_wstrb_i[b]) mem[w_idx][b*8 +: 8] <= axi_wdata_i[b*8 +: 8];
    end
endmodule

// File: tb/tb_iob_cache_axi_mem_responder.sv
// tb_iob_cache_axi_mem_responder: directed and randomized bursts checked against a word-array memory model
module tb_iob_cache_axi_mem_responder;
    localparam int D = 16;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [0:0]  axi_awid_i = '0, axi_arid_i = '0, axi_bid_o, axi_rid_o;
    logic [23:0] axi_awaddr_i = '0, axi_araddr_i = '0;
    logic [7:0]  axi_awlen_i = '0, axi_arlen_i = '0;
    logic        axi_awvalid_i = 0, axi_wlast_i = 0, axi_wvalid_i = 0, axi_bready_i = 0;
    logic        axi_arvalid_i = 0, axi_rready_i = 0;
    logic [31:0] axi_wdata_i = '0, axi_rdata_o;
    logic [3:0]  axi_wstrb_i = '0;
    logic        axi_awready_o, axi_wready_o, axi_bvalid_o, axi_arready_o, axi_rlast_o, axi_rvalid_o;
    logic [1:0]  axi_bresp_o, axi_rresp_o;
    logic [31:0] ref_mem [D];
    logic [31:0] wd [32];
    logic [3:0]  ws [32];
    int checks = 0, passed = 0, fails = 0;

    always #5 clk_i = ~clk_i;

    iob_cache_axi_mem_responder #(.MEM_ADDR_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .axi_awid_i(axi_awid_i), .axi_awaddr_i(axi_awaddr_i), .axi_awlen_i(axi_awlen_i),
        .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
        .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i), .axi_wlast_i(axi_wlast_i),
        .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o),
        .axi_bid_o(axi_bid_o), .axi_bresp_o(axi_bresp_o), .axi_bvalid_o(axi_bvalid_o),
        .axi_bready_i(axi_bready_i),
        .axi_arid_i(axi_arid_i), .axi_araddr_i(axi_araddr_i), .axi_arlen_i(axi_arlen_i),
        .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
        .axi_rid_o(axi_rid_o), .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
        .axi_rlast_o(axi_rlast_o), .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [23:0] a);
        return int'(a >> 2) % D;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic id, input logic [23:0] addr, input int len, input int last_at, input int bdelay);
        int n, idx;
        axi_awid_i = id; axi_awaddr_i = addr; axi_awlen_i = 8'(len); axi_awvalid_i = 1;
        n = 0;
        while (!axi_awready_o && n < 100) begin tick(); n++; end
        chk("aw_wait", n < 100, 1);
        tick();
        axi_awvalid_i = 0;
        idx = widx(addr);
        for (int i = 0; i <= last_at; i++) begin
            axi_wdata_i = wd[i]; axi_wstrb_i = ws[i]; axi_wlast_i = (i == last_at); axi_wvalid_i = 1;
            n = 0;
            while (!axi_wready_o && n < 100) begin tick(); n++; end
            chk("w_wait", n < 100, 1);
            tick();
            for (int b = 0; b < 4; b++) if (ws[i][b]) ref_mem[idx][b*8 +: 8] = wd[i][b*8 +: 8];
            idx = (idx + 1) % D;
        end
        axi_wvalid_i = 0; axi_wlast_i = 0;
        for (int k = 0; k < bdelay; k++) begin
            chk("b_hold", {axi_bvalid_o, axi_awready_o, axi_bresp_o}, {2'b10, (last_at == len) ? 2'b00 : 2'b10});
            tick();
        end
        axi_bready_i = 1;
        n = 0;
        while (!axi_bvalid_o && n < 100) begin tick(); n++; end
        chk("b_wait", n < 100, 1);
        chk("bid", axi_bid_o, id);
        chk("bresp", axi_bresp_o, (last_at == len) ? 2'b00 : 2'b10);
        tick();
        axi_bready_i = 0;
        chk("b_done", {axi_bvalid_o, axi_awready_o, axi_wready_o}, 3'b010);
    endtask

    task automatic ar(input logic id, input logic [23:0] addr, input int len);
        int n;
        axi_arid_i = id; axi_araddr_i = addr; axi_arlen_i = 8'(len); axi_arvalid_i = 1;
        n = 0;
        while (!axi_arready_o && n < 100) begin tick(); n++; end
        chk("ar_wait", n < 100, 1);
        tick();
        axi_arvalid_i = 0;
        chk("rvalid_lat", axi_rvalid_o, 1);
    endtask

    task automatic rd(input logic id, input logic [23:0] addr, input int len, input int stall_at, input int stall_n);
        int idx;
        ar(id, addr, len);
        idx = widx(addr);
        axi_rready_i = 1;
        for (int i = 0; i <= len; i++) begin
            chk("rbeat", {axi_rvalid_o, axi_rlast_o, axi_rid_o, axi_rresp_o}, {1'b1, i == len, id, 2'b00});
            chk("rdata", axi_rdata_o, ref_mem[idx]);
            tick();
            idx = (idx + 1) % D;
            if (i == stall_at && i < len) begin
                axi_rready_i = 0;
                for (int k = 0; k < stall_n; k++) begin
                    chk("r_hold", {axi_rvalid_o, axi_rlast_o, axi_rdata_o}, {1'b1, (i + 1) == len, ref_mem[idx]});
                    tick();
                end
                axi_rready_i = 1;
            end
        end
        axi_rready_i = 0;
        chk("r_end", {axi_rvalid_o, axi_arready_o}, 2'b01);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_out", {axi_awready_o, axi_arready_o, axi_wready_o, axi_bvalid_o, axi_rvalid_o, axi_rlast_o}, 0);
        rst_i = 0;
        chk("rdy_in_rel", {axi_awready_o, axi_arready_o}, 2'b00);
        tick();
        chk("rdy_after_rst", {axi_awready_o, axi_arready_o}, 2'b11);
        // fill the whole RAM so every model word is known
        for (int i = 0; i < D; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        wr(0, 24'h0, D - 1, D - 1, 0);
        rd(0, 24'h0, D - 1, -1, 0);
        // basic 4-beat burst
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        wr(1, 24'h40, 3, 3, 0);
        rd(1, 24'h40, 3, -1, 0);
        // byte strobes merge into an existing word
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        wr(0, 24'h08, 0, 0, 0);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        wr(0, 24'h08, 0, 0, 0);
        chk("merge_model", ref_mem[2], 32'h11BB33DD);
        rd(0, 24'h08, 0, -1, 0);
        // back-pressure on R and B
        rd(1, 24'h10, 5, 1, 3);
        for (int i = 0; i < 2; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        wr(0, 24'h20, 1, 1, 5);
        // early wlast gives SLVERR, then a clean burst is OKAY again
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        wr(1, 24'h30, 3, 1, 0);
        wr(1, 24'h30, 3, 3, 0);
        rd(1, 24'h30, 3, -1, 0);
        // index wraps past the top of the RAM; unused address bits ignored
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        wr(0, 24'hABCD3B, 3, 3, 2);
        rd(1, 24'h000038, 3, -1, 0);
        rd(0, 24'h000000, 1, -1, 0);
        // reset in the middle of a read burst
        ar(1, 24'h0, 7);
        axi_rready_i = 1;
        tick();
        tick();
        axi_rready_i = 0;
        rst_i = 1;
        tick();
        chk("rst_mid_rvalid", {axi_rvalid_o, axi_arready_o}, 2'b00);
        rst_i = 0;
        chk("rst_mid_rel", axi_arready_o, 0);
        tick();
        chk("rst_mid_arready", {axi_arready_o, axi_awready_o}, 2'b11);
        rd(0, 24'h0, D - 1, -1, 0);
        // randomized bursts
        for (int t = 0; t < 20; t++) begin
            int len, la, st;
            logic [23:0] a;
            len = $urandom_range(0, 7);
            la = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : len;
            a = 24'($urandom);
            for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            wr(1'($urandom), a, len, la, $urandom_range(0, 3));
            st = $urandom_range(0, 7);
            rd(1'($urandom), 24'($urandom), $urandom_range(0, 7), st, $urandom_range(0, 3));
            rd(1'($urandom), a, len, -1, 0);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
